// File: rtl/inta_sequencer.sv
// inta_sequencer: 8259A-style INTA sequencer (8086 mode), master/slave cascade side.
// Ports:
//   clk, rstn            clock, async active-low reset
//   INTAn                synchronized CPU acknowledge (active low)
//   SPENn, sngl          role select: master when SPENn=1 or sngl=1
//   aeoi                 automatic EOI enable
//   vec_base             vector base T7..T3
//   slave_map, slave_id  master/slave ICW3
//   irq_pend, irq_level  resolved request from the priority logic
//   cas_in               cascade lines as seen by this device
//   cas_out, cas_oe      cascade drive (master only)
//   d_out, d_oe          vector byte drive
//   isr_set, auto_eoi    one-cycle ISR set/clear strobes for isr_lvl
//   isr_lvl              level latched for the current sequence
//   freeze               holds IRR/priority stable during a sequence
module inta_sequencer #(
    parameter int VEC_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             INTAn,
    input  logic             SPENn,
    input  logic             sngl,
    input  logic             aeoi,
    input  logic [VEC_W-1:0] vec_base,
    input  logic [7:0]       slave_map,
    input  logic [2:0]       slave_id,
    input  logic             irq_pend,
    input  logic [2:0]       irq_level,
    input  logic [2:0]       cas_in,
    output logic [2:0]       cas_out,
    output logic             cas_oe,
    output logic [7:0]       d_out,
    output logic             d_oe,
    output logic             isr_set,
    output logic [2:0]       isr_lvl,
    output logic             auto_eoi,
    output logic             freeze
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P1   = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_P2   = 3'd3;
    localparam logic [2:0] S_END  = 3'd4;

    logic [2:0] state_q, state_d;
    logic       prev_q, prev_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_q, spur_d;
    logic       casc_q, casc_d;
    logic       master_q, master_d;
    logic       issued_q, issued_d;
    logic [2:0] cas_out_q, cas_out_d;
    logic       cas_oe_q, cas_oe_d;
    logic [7:0] d_out_q, d_out_d;
    logic       d_oe_q, d_oe_d;
    logic       isr_set_q, isr_set_d;
    logic       auto_eoi_q, auto_eoi_d;
    logic       freeze_q, freeze_d;

    logic       fall, rise, go_p1, go_p2, go_end;
    logic       role_m, new_casc, sel, drive;
    logic [2:0] new_lvl;

    always_comb begin
        fall       = prev_q & ~INTAn;
        rise       = ~prev_q & INTAn;
        go_p1      = (state_q == S_IDLE) & fall;
        go_p2      = (state_q == S_GAP) & fall;
        go_end     = (state_q == S_P2) & rise;
        role_m     = SPENn | sngl;
        new_lvl    = irq_pend ? irq_level : 3'd7;
        new_casc   = role_m & ~sngl & slave_map[new_lvl] & irq_pend;
        // slave owns the cycle only if it had a real request and CAS names it
        sel        = ~spur_q & (cas_in == slave_id);
        drive      = master_q ? ~casc_q : sel;
        prev_d     = INTAn;
        // a fall seen in END is ignored because END always returns to IDLE
        state_d    = go_p1 ? S_P1 :
                     ((state_q == S_P1) & rise) ? S_GAP :
                     go_p2 ? S_P2 :
                     go_end ? S_END :
                     (state_q >= S_END) ? S_IDLE : state_q;
        lvl_d      = go_p1 ? new_lvl : lvl_q;
        spur_d     = go_p1 ? ~irq_pend : spur_q;
        casc_d     = go_p1 ? new_casc : casc_q;
        master_d   = go_p1 ? role_m : master_q;
        isr_set_d  = (go_p1 & role_m & irq_pend) | (go_p2 & ~master_q & sel);
        issued_d   = isr_set_d | (~go_p1 & issued_q);
        auto_eoi_d = go_end & aeoi & issued_q;
        cas_oe_d   = go_p1 ? new_casc : go_end ? 1'b0 : cas_oe_q;
        cas_out_d  = go_p1 ? (new_casc ? new_lvl : 3'd0) : go_end ? 3'd0 : cas_out_q;
        d_oe_d     = go_p2 ? drive : go_end ? 1'b0 : d_oe_q;
        d_out_d    = (go_p2 & drive) ? {vec_base, lvl_q} : go_end ? 8'd0 : d_out_q;
        freeze_d   = go_p1 | (freeze_q & (state_q != S_END));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            prev_q     <= 1'b1;
            lvl_q      <= 3'd0;
            spur_q     <= 1'b0;
            casc_q     <= 1'b0;
            master_q   <= 1'b0;
            issued_q   <= 1'b0;
            cas_out_q  <= 3'd0;
            cas_oe_q   <= 1'b0;
            d_out_q    <= 8'd0;
            d_oe_q     <= 1'b0;
            isr_set_q  <= 1'b0;
            auto_eoi_q <= 1'b0;
            freeze_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            lvl_q      <= lvl_d;
            spur_q     <= spur_d;
            casc_q     <= casc_d;
            master_q   <= master_d;
            issued_q   <= issued_d;
            cas_out_q  <= cas_out_d;
            cas_oe_q   <= cas_oe_d;
            d_out_q    <= d_out_d;
            d_oe_q     <= d_oe_d;
            isr_set_q  <= isr_set_d;
            auto_eoi_q <= auto_eoi_d;
            freeze_q   <= freeze_d;
        end
    end

    assign cas_out  = cas_out_q;
    assign cas_oe   = cas_oe_q;
    assign d_out    = d_out_q;
    assign d_oe     = d_oe_q;
    assign isr_set  = isr_set_q;
    assign isr_lvl  = lvl_q;
    assign auto_eoi = auto_eoi_q;
    assign freeze   = freeze_q;
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: scoreboard bench for inta_sequencer.
module tb_inta_sequencer;
    logic       clk = 0, rstn = 0, INTAn = 1, SPENn = 1, sngl = 1, aeoi = 0;
    logic [4:0] vec_base = 0;
    logic [7:0] slave_map = 0;
    logic [2:0] slave_id = 0, irq_level = 0, cas_in = 0;
    logic       irq_pend = 0;
    logic [2:0] cas_out, isr_lvl;
    logic [7:0] d_out;
    logic       cas_oe, d_oe, isr_set, auto_eoi, freeze;

    inta_sequencer #(.VEC_W(5)) dut (
        .clk(clk), .rstn(rstn), .INTAn(INTAn), .SPENn(SPENn), .sngl(sngl), .aeoi(aeoi),
        .vec_base(vec_base), .slave_map(slave_map), .slave_id(slave_id),
        .irq_pend(irq_pend), .irq_level(irq_level), .cas_in(cas_in),
        .cas_out(cas_out), .cas_oe(cas_oe), .d_out(d_out), .d_oe(d_oe),
        .isr_set(isr_set), .isr_lvl(isr_lvl), .auto_eoi(auto_eoi), .freeze(freeze)
    );

    always #5 clk = ~clk;

    typedef struct {
        int set_cnt; int set_lvl; int set_ph; int set_dly;
        int casoe_cyc; int casout;
        int doe_cyc; int dout; int doe_dly;
        int eoi_cnt; int eoi_lvl; int eoi_gap; int overlap;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;
    int   cyc = 0, fall1 = 0, fall2 = 0, pulse = 0, eoi_cyc = 0;
    int   n_cmp = 0, n_bad = 0;
    bit   frz_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic rec_t model(bit spen, bit sg, bit [7:0] smap, bit pend, bit [2:0] lv,
                                   bit [4:0] vb, bit [2:0] sid, bit [2:0] cas, bit ae,
                                   int l1, int g, int l2);
        rec_t e = '{default: 0};
        bit [2:0] l = pend ? lv : 3'd7;
        bit [7:0] vec = {vb, l};
        if (spen || sg) begin
            if (pend) begin e.set_cnt = 1; e.set_lvl = l; e.set_ph = 1; e.set_dly = 1; end
            if (!sg && smap[l] && pend) begin
                e.casoe_cyc = l1 + g + l2; e.casout = l;
            end else begin
                e.doe_cyc = l2; e.dout = vec; e.doe_dly = 1;
            end
        end else if (pend && cas == sid) begin
            e.set_cnt = 1; e.set_lvl = l; e.set_ph = 2; e.set_dly = 1;
            e.doe_cyc = l2; e.dout = vec; e.doe_dly = 1;
        end
        if (ae && e.set_cnt != 0) begin e.eoi_cnt = 1; e.eoi_lvl = l; e.eoi_gap = 1; end
        return e;
    endfunction

    task automatic compare(input rec_t o, input rec_t e);
        check("set_cnt", o.set_cnt, e.set_cnt);
        check("set_lvl", o.set_lvl, e.set_lvl);
        check("set_ph", o.set_ph, e.set_ph);
        check("set_dly", o.set_dly, e.set_dly);
        check("casoe_cyc", o.casoe_cyc, e.casoe_cyc);
        check("cas_out", o.casout, e.casout);
        check("doe_cyc", o.doe_cyc, e.doe_cyc);
        check("d_out", o.dout, e.dout);
        check("doe_dly", o.doe_dly, e.doe_dly);
        check("eoi_cnt", o.eoi_cnt, e.eoi_cnt);
        check("eoi_lvl", o.eoi_lvl, e.eoi_lvl);
        check("eoi_to_unfreeze", o.eoi_gap, e.eoi_gap);
        check("set_eoi_overlap", o.overlap, e.overlap);
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            cur = '{default: 0};
            frz_prev = 0;
        end else begin
            if (isr_set) begin
                cur.set_cnt += 1; cur.set_lvl = isr_lvl; cur.set_ph = pulse;
                cur.set_dly = cyc - ((pulse == 2) ? fall2 : fall1);
            end
            if (isr_set && auto_eoi) cur.overlap += 1;
            if (cas_oe) begin cur.casoe_cyc += 1; cur.casout = cas_out; end
            if (d_oe) begin
                if (cur.doe_cyc == 0) cur.doe_dly = cyc - fall2;
                cur.doe_cyc += 1; cur.dout = d_out;
            end
            if (auto_eoi) begin cur.eoi_cnt += 1; cur.eoi_lvl = isr_lvl; eoi_cyc = cyc; end
            if (frz_prev && !freeze) begin
                if (cur.eoi_cnt != 0) cur.eoi_gap = cyc - eoi_cyc;
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else compare(cur, exp_q.pop_front());
                cur = '{default: 0};
            end
            frz_prev = freeze;
        end
    end

    task automatic seq(input bit spen, input bit sg, input bit [7:0] smap, input bit pend,
                       input bit [2:0] lv, input bit [4:0] vb, input bit [2:0] sid,
                       input bit [2:0] cas, input bit ae, input int l1, input int g,
                       input int l2, input bit scr);
        SPENn = spen; sngl = sg; slave_map = smap; irq_pend = pend; irq_level = lv;
        vec_base = vb; slave_id = sid; cas_in = cas; aeoi = ae;
        exp_q.push_back(model(spen, sg, smap, pend, lv, vb, sid, cas, ae, l1, g, l2));
        @(posedge clk); #2; INTAn = 0; fall1 = cyc; pulse = 1;
        repeat (l1) @(posedge clk);
        #2; INTAn = 1;
        if (scr) begin irq_pend = ~pend; irq_level = ~lv; end
        repeat (g) @(posedge clk);
        #2; INTAn = 0; fall2 = cyc; pulse = 2;
        repeat (l2) @(posedge clk);
        #2; INTAn = 1;
        repeat (4) @(posedge clk);
        #2; pulse = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end within time limit");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_cas_oe", cas_oe, 0);
        check("rst_d_oe", d_oe, 0);
        check("rst_isr_set", isr_set, 0);
        check("rst_freeze", freeze, 0);
        check("rst_isr_lvl", isr_lvl, 0);
        check("rst_d_out", d_out, 0);
        repeat (3) @(posedge clk);
        #2; rstn = 1;
        repeat (2) @(posedge clk);
        //   spen sg smap   pend lv  vb     sid cas ae l1 g l2 scr
        seq(1, 1, 8'h00, 1, 3, 5'h08, 0, 0, 0, 1, 1, 1, 0);
        seq(1, 1, 8'h00, 1, 3, 5'h08, 0, 0, 0, 2, 3, 2, 0);
        seq(1, 0, 8'h04, 1, 2, 5'h08, 0, 0, 0, 2, 2, 2, 0);
        seq(1, 0, 8'h04, 1, 5, 5'h08, 0, 0, 0, 1, 2, 3, 0);
        seq(0, 0, 8'h00, 1, 6, 5'h10, 5, 5, 0, 2, 1, 2, 0);
        seq(0, 0, 8'h00, 1, 6, 5'h10, 5, 4, 0, 2, 1, 2, 0);
        seq(1, 1, 8'h00, 0, 2, 5'h08, 0, 0, 1, 1, 2, 1, 0);
        seq(1, 1, 8'h00, 1, 1, 5'h08, 0, 0, 1, 2, 2, 2, 0);
        seq(0, 0, 8'h00, 1, 3, 5'h1F, 2, 2, 1, 1, 1, 1, 0);
        seq(0, 0, 8'h00, 0, 3, 5'h10, 7, 7, 1, 1, 1, 1, 0);
        seq(1, 1, 8'h00, 1, 4, 5'h0C, 0, 0, 0, 1, 2, 2, 1);
        seq(1, 0, 8'h80, 1, 7, 5'h02, 0, 0, 1, 1, 1, 1, 1);
        // abort a cascade sequence with reset while in the gap
        SPENn = 1; sngl = 0; slave_map = 8'h04; irq_pend = 1; irq_level = 2; aeoi = 1;
        @(posedge clk); #2; INTAn = 0;
        repeat (2) @(posedge clk);
        #2; INTAn = 1;
        @(posedge clk); #3;
        check("gap_cas_oe", cas_oe, 1);
        check("gap_freeze", freeze, 1);
        rstn = 0;
        #1;
        check("abort_cas_oe", cas_oe, 0);
        check("abort_freeze", freeze, 0);
        check("abort_d_oe", d_oe, 0);
        check("abort_auto_eoi", auto_eoi, 0);
        repeat (2) @(posedge clk);
        #2; rstn = 1;
        repeat (2) @(posedge clk);
        seq(1, 0, 8'h04, 1, 2, 5'h08, 0, 0, 1, 1, 1, 2, 0);
        seq(1, 1, 8'h00, 1, 0, 5'h15, 0, 0, 0, 1, 1, 1, 0);
        repeat (5) @(posedge clk);
        check("sb_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

Interrupt-acknowledge sequencer for the 8259A-style PIC, 8086 mode. It is the driving end of the cascade bus. As master, it decodes the CPU's INTA pulses, commits the resolved request to the ISR, drives the interrupting slave's ID onto CAS, and places the vector on the data bus when no slave owns the cycle. As slave, it is the counterpart that decides, from the CAS value at the second pulse, whether it supplies the vector. It sits between the priority resolver / ISR logic and the data-bus buffer.

## Interface
- `VEC_W`, 5: width of ICW2 vector base (T7..T3).
- `clk` input 1: system clock; all state is on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `INTAn` input 1: CPU acknowledge, active-low, already synchronized to `clk`.
- `SPENn` input 1: 1 = master, 0 = slave.
- `sngl` input 1: ICW1 SNGL; 1 = no cascade, block behaves as master with no slaves.
- `aeoi` input 1: ICW4 AEOI.
- `vec_base` input VEC_W: ICW2 T7..T3.
- `slave_map` input 8: master ICW3; bit n = 1 means IRn has a slave.
- `slave_id` input 3: slave ICW3 ID.
- `irq_pend` input 1: resolver has an unmasked request above the current ISR priority.
- `irq_level` input 3: level of that request.
- `cas_in` input 3: CAS lines as seen by this device.
- `cas_out` output 3: CAS value driven.
- `cas_oe` output 1: CAS output enable.
- `d_out` output 8: vector byte.
- `d_oe` output 1: data-bus output enable.
- `isr_set` output 1: one-cycle strobe that sets ISR bit `isr_lvl`.
- `isr_lvl` output 3: level latched for this sequence.
- `auto_eoi` output 1: one-cycle strobe that clears ISR bit `isr_lvl`.
- `freeze` output 1: holds IRR/priority inputs stable while a sequence is active.

## Operation
- Edge detect: a 1-bit register holds the previous `INTAn`. Fall = prev 1 and cur 0. Rise = prev 0 and cur 1.
- States:
  - IDLE: fall → P1.
  - P1: rise → GAP.
  - GAP: fall → P2.
  - P2: rise → END.
  - END: always → IDLE next cycle.
  - A fall seen in END is ignored.
- On the fall that enters P1:
  - latch `lvl` = `irq_pend ? irq_level : 3'd7`
  - latch `spur` = `~irq_pend`
  - assert `freeze`
- Role is master when `SPENn`=1 or `sngl`=1.
- Master:
  - `casc` = `~sngl & slave_map[lvl] & ~spur`, latched at P1 entry.
  - `isr_set` pulses on P1 entry unless `spur`.
  - If `casc`: `cas_out`=`lvl` and `cas_oe`=1 from P1 entry until END. Data is never driven.
  - Else: `d_oe`=1 and `d_out`={`vec_base`, `lvl`} from P2 entry until END.
- Slave:
  - `cas_oe` is always 0.
  - At the fall that enters P2: `sel` = `irq_pend_latched & (cas_in == slave_id)`.
  - If `sel`: `isr_set` pulses on P2 entry, and `d_out`={`vec_base`, `lvl`} with `d_oe`=1 from P2 entry until END.
  - Else: nothing is driven and the ISR is unchanged.
- Spurious sequence (no request at P1): vector = base|7, no `isr_set`, no `auto_eoi`.
- `auto_eoi` pulses on END entry when `aeoi`=1 and an `isr_set` was issued in this sequence.
- `freeze` deasserts on END→IDLE.

## Timing
- Reset values: state IDLE, prev `INTAn`=1, all outputs 0, `isr_lvl`=0.
- Reset asserted mid-sequence aborts immediately: outputs drop asynchronously and there is no `auto_eoi`.
- All outputs are registered.
- `cas_oe` and the master `isr_set` are visible in the cycle after the clock that samples `INTAn`=0 (latency 1 from the sampled fall).
- `d_oe` is visible 1 cycle after the second sampled fall. It drops 1 cycle after the second sampled rise.
- Minimum INTA low/high width is 1 cycle. Shorter glitches are not required to be seen.
- `irq_pend`/`irq_level` changes after P1 entry do not affect the sequence (latched).
- `cas_in` is sampled only at P2 entry. The master's CAS is stable by then because `cas_oe` rises 1 cycle after the P1 fall and GAP lasts ≥1 cycle.
- `isr_set` and `auto_eoi` never occur in the same cycle.

## Test plan
- Master, `sngl`=1, `vec_base`=5'h08, IR3 pending, two INTA pulses → `isr_set`@P1 with `isr_lvl`=3; `d_out`=8'h43, `d_oe`=1 during pulse 2 only; `cas_oe`=0 throughout.
- Master cascade, `slave_map`=8'h04, IR2 pending → `cas_out`=3'd2 with `cas_oe`=1 from P1 to END; `d_oe`=0 throughout; `isr_set` with level 2.
- Slave, `slave_id`=5, `vec_base`=5'h10, IR6 pending, `cas_in`=5 at pulse 2 → `isr_set` level 6 at P2; `d_out`=8'h86. Repeat with `cas_in`=4 → no `d_oe`, no `isr_set`.
- Spurious: master with `irq_pend`=0 at the first fall, `vec_base`=5'h08 → `d_out`=8'h47, no `isr_set`, no `auto_eoi`.
- AEOI: `aeoi`=1, IR1 → `auto_eoi` pulse exactly 1 cycle on END entry with `isr_lvl`=1; `freeze` low on the following cycle.
- Reset mid-sequence: assert `rstn`=0 during GAP with `cas_oe`=1 → `cas_oe`, `freeze` and `d_oe` go 0 without a clock edge. After release, a new INTA pair completes normally.
